puf_resp_gen: RTL and testbench

Downstream stage of the oscillator measurement block. Stores the per-oscillator edge counts the measurement stage produces, then walks a challenge table in the external memory. Each challenge entry names two oscillators; the block compares their counts and assembles one response bit per challenge into the primary ID word. Runs entirely in the system clock domain.

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_resp_gen_cnt_regfile.sv | 52 +++++
 rtl/puf_resp_gen.sv | 178 +++++++++++++++++
 tb/tb_puf_resp_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default constants for the PUF response generator and the
// oscillator measurement stage that feeds it.
package puf_pkg;

  localparam int unsigned C_IOSCNUM_DEF      = 48;
  localparam int unsigned C_IOSCDWIDTH_DEF   = 24;
  localparam int unsigned C_OIDWIDTH_DEF     = 24;
  localparam int unsigned C_MEMDATAWIDTH_DEF = 8;
  localparam int unsigned C_MEMADDRWIDTH_DEF = 24;
  localparam int unsigned C_CHALBASE_DEF     = 0;

  localparam int unsigned C_IDXW = $clog2(C_IOSCNUM_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_CMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/puf_resp_gen_cnt_regfile.sv
// Oscillator count register file: one synchronous write port, one asynchronous
// read port, and a per-entry loaded bitmap with a clear input.
module cnt_regfile import puf_pkg::*; #(
  parameter int unsigned N  = C_IOSCNUM_DEF,
  parameter int unsigned DW = C_IOSCDWIDTH_DEF,
  parameter int unsigned IW = C_IDXW
) (
  input  logic          I_sclk,
  input  logic          I_rst,
  input  logic          I_we,
  input  logic [IW-1:0] I_wr_idx,
  input  logic [DW-1:0] I_wr_data,
  input  logic [IW-1:0] I_rd_idx,
  output logic [DW-1:0] O_rd_data,
  input  logic          I_clr,
  output logic          O_all_loaded
);

  localparam logic [IW:0] NUM_L = (IW+1)'(N);

  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];
  logic [N-1:0]  loaded_q, loaded_d;
  logic [N-1:0]  wr_mask;

  always_comb begin
    cnt_d   = cnt_q;
    wr_mask = '0;
    if (I_we) begin
      cnt_d[I_wr_idx]   = I_wr_data;
      wr_mask[I_wr_idx] = 1'b1;
    end
    loaded_d = I_clr ? '0 : (loaded_q | wr_mask);
  end

  // A write landing in the same cycle as a start must count as loaded.
  assign O_all_loaded = &(loaded_q | wr_mask);
  assign O_rd_data    = ({1'b0, I_rd_idx} < NUM_L) ? cnt_q[I_rd_idx] : '0;

  // NOTE: the count file is reset on purpose so a run after reset can never
  // compare stale counts; this costs reset fan-out but the file is small.
  always_ff @(posedge I_sclk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
      loaded_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: rtl/puf_resp_gen.sv
// PUF response generator: stores oscillator counts, walks the challenge table
// and assembles one response bit per challenge into the primary ID.
module puf_resp_gen import puf_pkg::*; #(
  parameter int unsigned C_IOSCNUM      = C_IOSCNUM_DEF,
  parameter int unsigned C_IOSCDWIDTH   = C_IOSCDWIDTH_DEF,
  parameter int unsigned C_OIDWIDTH     = C_OIDWIDTH_DEF,
  parameter int unsigned C_MEMDATAWIDTH = C_MEMDATAWIDTH_DEF,
  parameter int unsigned C_MEMADDRWIDTH = C_MEMADDRWIDTH_DEF,
  parameter int unsigned C_CHALBASE     = C_CHALBASE_DEF
) (
  input  logic                      I_sclk,
  input  logic                      I_rst,
  input  logic                      I_cnt_valid,
  input  logic [C_IDXW-1:0]         I_cnt_idx,
  input  logic [C_IOSCDWIDTH-1:0]   I_cnt_data,
  output logic                      O_cnt_ready,
  input  logic                      I_start,
  output logic                      O_busy,
  output logic [C_MEMADDRWIDTH-1:0] O_mem_addr,
  input  logic [C_MEMDATAWIDTH-1:0] I_mem_data,
  output logic [C_OIDWIDTH-1:0]     O_prim_id,
  output logic                      O_id_valid,
  output logic                      O_err
);

  localparam int unsigned KW     = $clog2(C_OIDWIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(C_OIDWIDTH - 1);
  localparam logic [C_IDXW:0] NUM_L = (C_IDXW+1)'(C_IOSCNUM);

  state_e                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [C_MEMADDRWIDTH-1:0] addr_q, addr_d;
  logic [C_IOSCDWIDTH-1:0]   cnt_a_q, cnt_a_d;
  logic                      a_bad_q, a_bad_d;
  logic [C_OIDWIDTH-1:0]     shadow_q, shadow_d;
  logic [C_OIDWIDTH-1:0]     prim_id_q, prim_id_d;
  logic                      id_valid_q, id_valid_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;

  logic                    wr_acc, wr_ok, rd_ok, all_loaded, cmp_bit;
  logic [C_IDXW-1:0]       rd_idx;
  logic [C_IOSCDWIDTH-1:0] rd_data;
  logic                    unused_mem_hi;

  // Ready is high exactly in IDLE, so it doubles as the IDLE qualifier.
  assign wr_acc        = I_cnt_valid & ready_q;
  assign wr_ok         = {1'b0, I_cnt_idx} < NUM_L;
  assign rd_idx        = I_mem_data[C_IDXW-1:0];
  assign rd_ok         = {1'b0, rd_idx} < NUM_L;
  assign unused_mem_hi = ^I_mem_data;

  cnt_regfile #(
    .N  (C_IOSCNUM),
    .DW (C_IOSCDWIDTH),
    .IW (C_IDXW)
  ) u_cnt_regfile (
    .I_sclk       (I_sclk),
    .I_rst        (I_rst),
    .I_we         (wr_acc & wr_ok),
    .I_wr_idx     (I_cnt_idx),
    .I_wr_data    (I_cnt_data),
    .I_rd_idx     (rd_idx),
    .O_rd_data    (rd_data),
    .I_clr        (state_q == ST_DONE),
    .O_all_loaded (all_loaded)
  );

  function automatic logic [C_MEMADDRWIDTH-1:0] chal_addr(input logic [KW-1:0] kk,
                                                          input logic odd);
    return C_MEMADDRWIDTH'(C_CHALBASE) + C_MEMADDRWIDTH'({kk, odd});
  endfunction

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    addr_d     = addr_q;
    cnt_a_d    = cnt_a_q;
    a_bad_d    = a_bad_q;
    shadow_d   = shadow_q;
    prim_id_d  = prim_id_q;
    id_valid_d = 1'b0;
    err_d      = err_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    cmp_bit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          if (all_loaded) begin
            err_d   = 1'b0;
            k_d     = '0;
            addr_d  = chal_addr('0, 1'b0);
            busy_d  = 1'b1;
            ready_d = 1'b0;
            state_d = ST_FETCH_A;
          end else begin
            err_d = 1'b1;
          end
        end
        if (wr_acc && !wr_ok) err_d = 1'b1;
      end
      ST_FETCH_A: begin
        addr_d  = chal_addr(k_q, 1'b1);
        state_d = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        cnt_a_d = rd_data;
        a_bad_d = !rd_ok;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        cmp_bit       = !a_bad_q && rd_ok && (cnt_a_q > rd_data);
        shadow_d[k_q] = cmp_bit;
        if (a_bad_q || !rd_ok) err_d = 1'b1;
        if (k_q == K_LAST) begin
          // ID and its valid pulse appear together in the DONE cycle.
          prim_id_d  = shadow_d;
          id_valid_d = 1'b1;
          addr_d     = '0;
          state_d    = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          addr_d  = chal_addr(k_q + 1'b1, 1'b0);
          state_d = ST_FETCH_A;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge I_sclk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      addr_q     <= '0;
      cnt_a_q    <= '0;
      a_bad_q    <= 1'b0;
      shadow_q   <= '0;
      prim_id_q  <= '0;
      id_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      cnt_a_q    <= cnt_a_d;
      a_bad_q    <= a_bad_d;
      shadow_q   <= shadow_d;
      prim_id_q  <= prim_id_d;
      id_valid_q <= id_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign O_cnt_ready = ready_q;
  assign O_busy      = busy_q;
  assign O_mem_addr  = addr_q;
  assign O_prim_id   = prim_id_q;
  assign O_id_valid  = id_valid_q;
  assign O_err       = err_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Scoreboard bench for puf_resp_gen: directed count loads and challenge
// tables, expected IDs queued at start and checked when O_id_valid pulses.
module tb_puf_resp_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        I_cnt_valid = 1'b0;
  logic [5:0]  I_cnt_idx = '0;
  logic [23:0] I_cnt_data = '0;
  logic        O_cnt_ready;
  logic        I_start = 1'b0;
  logic        O_busy;
  logic [23:0] O_mem_addr;
  logic [7:0]  I_mem_data = '0;
  logic [23:0] O_prim_id;
  logic        O_id_valid;
  logic        O_err;

  puf_resp_gen dut (
    .I_sclk      (clk),
    .I_rst       (rst),
    .I_cnt_valid (I_cnt_valid),
    .I_cnt_idx   (I_cnt_idx),
    .I_cnt_data  (I_cnt_data),
    .O_cnt_ready (O_cnt_ready),
    .I_start     (I_start),
    .O_busy      (O_busy),
    .O_mem_addr  (O_mem_addr),
    .I_mem_data  (I_mem_data),
    .O_prim_id   (O_prim_id),
    .O_id_valid  (O_id_valid),
    .O_err       (O_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Challenge memory: read data valid one cycle after the address.
  logic [7:0] mem [64];
  always @(posedge clk) I_mem_data <= (O_mem_addr < 24'd64) ? mem[O_mem_addr[5:0]] : 8'h00;

  typedef struct {
    logic [23:0] id;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ID pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (O_id_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_id_valid", 32'(O_id_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("prim_id", 32'(O_prim_id), 32'(e.id));
        check("err_at_done", 32'(O_err), 32'(e.err));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic load(input int skip);
    for (int i = 0; i < 48; i++) begin
      if (i != skip) begin
        @(negedge clk);
        I_cnt_valid = 1'b1;
        I_cnt_idx   = 6'(i);
        I_cnt_data  = 24'(1000 + i);
      end
    end
    @(negedge clk);
    I_cnt_valid = 1'b0;
  endtask

  // mode 0: (2k,2k+1); mode 1: (2k+1,2k) with junk upper bits; mode 2: odd k ties.
  task automatic set_chal(input int mode, input int bad_k);
    int a, b;
    logic [7:0] hi;
    for (int k = 0; k < 24; k++) begin
      hi = (mode == 1) ? 8'hC0 : 8'h00;
      if (mode == 0)           begin a = 2*k;     b = 2*k + 1; end
      else if (mode == 1)      begin a = 2*k + 1; b = 2*k;     end
      else if ((k % 2) == 0)   begin a = 2*k + 1; b = 2*k;     end
      else                     begin a = 2*k;     b = 2*k;     end
      if (k == bad_k) a = 50;
      mem[2*k]     = 8'(a) | hi;
      mem[2*k + 1] = 8'(b) | hi;
    end
  endtask

  task automatic run(input logic [23:0] exp_id, input logic exp_err, input bit poke,
                     input int same_wr);
    exp_t e;
    @(negedge clk);
    I_start = 1'b1;
    if (same_wr >= 0) begin
      I_cnt_valid = 1'b1;
      I_cnt_idx   = 6'(same_wr);
      I_cnt_data  = 24'(1000 + same_wr);
    end
    e.id  = exp_id;
    e.err = exp_err;
    e.cyc = cyc + 73;
    sb.push_back(e);
    @(negedge clk);
    I_start     = 1'b0;
    I_cnt_valid = 1'b0;
    check("busy_after_start", 32'(O_busy), 32'd1);
    check("ready_in_run", 32'(O_cnt_ready), 32'd0);
    check("addr_fetch_a", 32'(O_mem_addr), 32'd0);
    @(negedge clk);
    check("addr_fetch_b", 32'(O_mem_addr), 32'd1);
    check("err_cleared_by_start", 32'(O_err), 32'd0);
    if (poke) begin
      I_cnt_valid = 1'b1;
      I_cnt_idx   = 6'd0;
      I_cnt_data  = 24'd5000;
      repeat (6) @(negedge clk);
      check("ready_during_poke", 32'(O_cnt_ready), 32'd0);
      I_cnt_valid = 1'b0;
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("run_completes", sb.size(), 0);
    @(negedge clk);
    check("ready_after_done", 32'(O_cnt_ready), 32'd1);
    check("busy_after_done", 32'(O_busy), 32'd0);
    check("prim_id_hold", 32'(O_prim_id), 32'(exp_id));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(O_cnt_ready), 32'd1);
    check({tag, "_busy"}, 32'(O_busy), 32'd0);
    check({tag, "_addr"}, 32'(O_mem_addr), 32'd0);
    check({tag, "_prim_id"}, 32'(O_prim_id), 32'd0);
    check({tag, "_id_valid"}, 32'(O_id_valid), 32'd0);
    check({tag, "_err"}, 32'(O_err), 32'd0);
  endtask

  task automatic refused_start(input string tag);
    @(negedge clk);
    I_start = 1'b1;
    @(negedge clk);
    I_start = 1'b0;
    check({tag, "_err"}, 32'(O_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(O_busy), 32'd0);
      check({tag, "_addr"}, 32'(O_mem_addr), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ascending pairs: every A < B, ID all zeros.
    load(-1);
    set_chal(0, -1);
    run(24'h000000, 1'b0, 1'b0, -1);

    // Reversed pairs with junk upper bits, writes attempted mid-run.
    load(-1);
    set_chal(1, -1);
    run(24'hFFFFFF, 1'b0, 1'b1, -1);

    // Only 47 counts loaded: start refused, no memory activity.
    load(20);
    refused_start("refused");
    check("prim_id_after_refuse", 32'(O_prim_id), 32'h00FFFFFF);

    // Missing count written in the start cycle; challenge 5 names index 50.
    set_chal(1, 5);
    run(24'hFFFFDF, 1'b1, 1'b0, 20);

    // Ties on odd challenges give 0.
    load(-1);
    set_chal(2, -1);
    run(24'h555555, 1'b0, 1'b0, -1);

    // Out-of-range count index is dropped and flags an error.
    check("err_before_bad_idx", 32'(O_err), 32'd0);
    @(negedge clk);
    I_cnt_valid = 1'b1;
    I_cnt_idx   = 6'd48;
    I_cnt_data  = 24'd7;
    @(negedge clk);
    I_cnt_valid = 1'b0;
    check("err_bad_idx", 32'(O_err), 32'd1);

    // Reset in the middle of a run.
    load(-1);
    set_chal(0, -1);
    @(negedge clk);
    I_start = 1'b1;
    @(negedge clk);
    I_start = 1'b0;
    repeat (29) @(negedge clk);
    check("busy_before_midreset", 32'(O_busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("prim_id_after_midreset", 32'(O_prim_id), 32'd0);
    refused_start("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
